// File: rtl/vmem_pkg.sv
// vmem_pkg: shared vector memory constants and FSM state encoding for load/store handlers
package vmem_pkg;
  localparam int ADDR_WIDTH     = 19;
  localparam int DEF_LANES      = 16;
  localparam int DEF_DATA_WIDTH = 16;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCALAR = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } vmem_state_e;
endpackage

// File: rtl/vector_load_handler_if.sv
// vector_load_handler_if: request/memory/result bundle; AddrWrapErr exists only with VLOAD_WRAP_CHECK_EN
interface vector_load_handler_if
  import vmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES
);
  logic [ADDR_WIDTH-1:0]             Address;
  logic                              Vectorop;
  logic                              ReadEn;
  logic [DATA_WIDTH-1:0]             MemorydataRead;
  logic [ADDR_WIDTH-1:0]             Out_Address;
  logic                              MemRead;
  logic                              BlockPipeLd;
  logic [DATA_WIDTH-1:0]             ScalarResult;
  logic                              ScalarValid;
  logic [LANES-1:0][DATA_WIDTH-1:0]  VectorResult;
  logic                              VectorValid;
`ifdef VLOAD_WRAP_CHECK_EN
  logic                              AddrWrapErr;
`endif
  modport master (
    output Address, Vectorop, ReadEn, MemorydataRead,
    input  Out_Address, MemRead, BlockPipeLd, ScalarResult, ScalarValid, VectorResult, VectorValid
`ifdef VLOAD_WRAP_CHECK_EN
    , input AddrWrapErr
`endif
  );
  modport slave (
    input  Address, Vectorop, ReadEn, MemorydataRead,
    output Out_Address, MemRead, BlockPipeLd, ScalarResult, ScalarValid, VectorResult, VectorValid
`ifdef VLOAD_WRAP_CHECK_EN
    , output AddrWrapErr
`endif
  );
endinterface

// File: rtl/vload_lane_counter.sv
// vload_lane_counter: burst lane counter with wrapping base+lane address adder
module vload_lane_counter
  import vmem_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  inc_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  output logic [LW-1:0]         lane_o,
  output logic                  last_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);
  logic [LW-1:0] lane_q, lane_d;
  assign lane_d = clr_i ? '0 : inc_i ? lane_q + 1'b1 : lane_q;
  assign lane_o = lane_q;
  assign last_o = lane_q == LW'(LANES - 1);
  assign addr_o = base_i + ADDR_WIDTH'(lane_q);
  // lane index register, cleared at burst start and stepped per issued lane
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lane_q <= '0;
    else lane_q <= lane_d;
endmodule

// File: rtl/vector_load_handler.sv
// vector_load_handler: scalar/vector memory load sequencer; VLOAD_WRAP_CHECK_EN adds the AddrWrapErr flag
module vector_load_handler
  import vmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vector_load_handler_if.slave  bus
);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  vmem_state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]            base_q, base_d;
  logic [ADDR_WIDTH-1:0]            out_addr_q, out_addr_d;
  logic                             mem_read_q, mem_read_d;
  logic                             block_q, block_d;
  logic [DATA_WIDTH-1:0]            sres_q, sres_d;
  logic                             svalid_q, svalid_d;
  logic                             vvalid_q, vvalid_d;
  logic [LW-1:0]                    cap_q, cap_d;
  logic [LANES-1:0][DATA_WIDTH-1:0] vres_q;
  logic                             vwe, cnt_clr, cnt_inc, last;
  logic [LW-1:0]                    lane;
  logic [ADDR_WIDTH-1:0]            cur_addr;
`ifdef VLOAD_WRAP_CHECK_EN
  logic                             wrap_q, wrap_d;
  logic [ADDR_WIDTH:0]              end_addr;
  assign end_addr = {1'b0, base_q} + (ADDR_WIDTH+1)'(LANES - 1);
  assign bus.AddrWrapErr = wrap_q;
`endif
  vload_lane_counter #(.LANES(LANES), .LW(LW)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .base_i (base_q),
    .lane_o (lane),
    .last_o (last),
    .addr_o (cur_addr)
  );
  assign bus.Out_Address  = out_addr_q;
  assign bus.MemRead      = mem_read_q;
  assign bus.BlockPipeLd  = block_q;
  assign bus.ScalarResult = sres_q;
  assign bus.ScalarValid  = svalid_q;
  assign bus.VectorResult = vres_q;
  assign bus.VectorValid  = vvalid_q;
  // next-state and registered-output decode; requests are only looked at in IDLE
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    out_addr_d = out_addr_q;
    mem_read_d = 1'b0;
    block_d    = block_q;
    sres_d     = sres_q;
    svalid_d   = 1'b0;
    vvalid_d   = 1'b0;
    cap_d      = cap_q;
    vwe        = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
`ifdef VLOAD_WRAP_CHECK_EN
    wrap_d     = 1'b0;
`endif
    case (state_q)
      IDLE:
        if (bus.ReadEn) begin
          if (bus.Vectorop) begin
            base_d  = bus.Address;
            cnt_clr = 1'b1;
            block_d = 1'b1;
            state_d = ISSUE;
          end else begin
            out_addr_d = bus.Address;
            mem_read_d = 1'b1;
            state_d    = SCALAR;
          end
        end
      SCALAR: begin
        sres_d   = bus.MemorydataRead;
        svalid_d = 1'b1;
        state_d  = IDLE;
      end
      ISSUE: begin
        out_addr_d = cur_addr;
        mem_read_d = 1'b1;
        cap_d      = lane;
        cnt_inc    = 1'b1;
        vwe        = mem_read_q;
        state_d    = last ? DRAIN : ISSUE;
      end
      DRAIN: begin
        vwe     = 1'b1;
        block_d = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        vvalid_d = 1'b1;
`ifdef VLOAD_WRAP_CHECK_EN
        wrap_d   = end_addr[ADDR_WIDTH];
`endif
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; a lane write lands one cycle after its address was presented
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      out_addr_q <= '0;
      mem_read_q <= 1'b0;
      block_q    <= 1'b0;
      sres_q     <= '0;
      svalid_q   <= 1'b0;
      vvalid_q   <= 1'b0;
      cap_q      <= '0;
      vres_q     <= '0;
`ifdef VLOAD_WRAP_CHECK_EN
      wrap_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      out_addr_q <= out_addr_d;
      mem_read_q <= mem_read_d;
      block_q    <= block_d;
      sres_q     <= sres_d;
      svalid_q   <= svalid_d;
      vvalid_q   <= vvalid_d;
      cap_q      <= cap_d;
      if (vwe) vres_q[cap_q] <= bus.MemorydataRead;
`ifdef VLOAD_WRAP_CHECK_EN
      wrap_q     <= wrap_d;
`endif
    end
endmodule
